// File: rtl/line_dedup_queue.sv
// line_dedup_queue: folds repeated cache-line addresses within a request and buffers survivors in a FIFO.
// Ports: clk/rst (sync, active-high); in_* upstream valid/ready stream (addr, bytes, last);
//   out_* FIFO head (addr, bytes, last, merges) with valid/ready; req_done one-cycle completion pulse;
//   busy = FIFO non-empty or request open.
// Optional: define LINE_DEDUP_WINDOW_EN to also merge against every live FIFO entry, not just the last address.
module line_dedup_queue #(
  parameter int ADDR_W   = 64,
  parameter int CL_BYTES = 128,
  parameter int DEPTH    = 4,
  parameter int MERGE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_bytes,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_bytes,
  output logic              out_last,
  output logic [MERGE_W-1:0] out_merges,
  output logic              req_done,
  output logic              busy
);
  localparam int OFF_W = $clog2(CL_BYTES);
  localparam int PW    = $clog2(DEPTH);
  logic [ADDR_W-1:0]  r_addr   [DEPTH];
  logic [15:0]        r_bytes  [DEPTH];
  logic               r_last   [DEPTH];
  logic [MERGE_W-1:0] r_merges [DEPTH];
  logic [PW-1:0]      r_rd, r_wr;
  logic [PW:0]        r_count;
  logic [ADDR_W-1:0]  r_last_addr;
  logic               r_last_valid, r_done;
  logic [ADDR_W-1:0]  w_line;
  logic [PW-1:0]      w_tail, w_hit_idx, w_midx;
  logic               w_acc, w_pop, w_dup, w_tail_ok, w_hit, w_merge, w_push, w_drop;
  assign w_line    = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign in_ready  = r_count != (PW+1)'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_dup     = r_last_valid && w_line == r_last_addr;
  assign w_tail    = r_wr - 1'b1;
  // the tail only survives this cycle if it is not also the head being popped
  assign w_tail_ok = out_valid && !(w_pop && r_count == (PW+1)'(1));
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
`ifdef LINE_DEDUP_WINDOW_EN
    // youngest live match wins; window merging stays within the open request
    for (int k = 0; k < DEPTH; k++) begin
      if (r_last_valid && 32'(r_count) > k && !(k == 0 && w_pop) && r_addr[r_rd + PW'(k)] == w_line) begin
        w_hit     = 1'b1;
        w_hit_idx = r_rd + PW'(k);
      end
    end
`endif
    // a last flag may only land on the tail, never ahead of younger entries
    w_merge = w_acc && (w_dup ? w_tail_ok : w_hit && (!in_last || w_hit_idx == w_tail));
    w_midx  = w_dup ? w_tail : w_hit_idx;
    w_drop  = w_acc && w_dup && !w_tail_ok;
    w_push  = w_acc && !w_dup && !w_merge;
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr]   <= w_line;
      r_bytes[r_wr]  <= in_bytes;
      r_last[r_wr]   <= in_last;
      r_merges[r_wr] <= '0;
    end
    if (w_merge) begin
      r_merges[w_midx] <= &r_merges[w_midx] ? r_merges[w_midx] : r_merges[w_midx] + 1'b1;
      r_last[w_midx]   <= r_last[w_midx] | in_last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_acc) begin
        r_last_addr  <= w_line;
        r_last_valid <= !in_last;
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= w_push && !w_pop ? r_count + 1'b1 : w_pop && !w_push ? r_count - 1'b1 : r_count;
      r_done  <= (w_drop && in_last) || (w_pop && r_last[r_rd]);
    end
  end
  assign out_addr   = out_valid ? r_addr[r_rd] : '0;
  assign out_bytes  = out_valid ? r_bytes[r_rd] : '0;
  assign out_last   = out_valid && r_last[r_rd];
  assign out_merges = out_valid ? r_merges[r_rd] : '0;
  assign req_done   = r_done;
  assign busy       = out_valid || r_last_valid;
endmodule

// File: doc/line_dedup_queue.md
Name: line_dedup_queue

Overview:
- Sits directly downstream of the strided/misaligned transaction generator and upstream of the L2/memory request port.
- Accepts the generator's stream of cache-line-aligned transactions and collapses repeated line addresses into one entry, so small strides do not cause repeated fetches of the same line.
- Buffers surviving transactions in a small FIFO and reports end-of-request completion.

Parameters:
- ADDR_W, 64, address width.
- CL_BYTES, 128, cache-line size in bytes; power of two. OFF_W = log2(CL_BYTES).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MERGE_W, 8, width of the per-entry merge counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  upstream may transfer; transfer occurs when in_valid && in_ready.
- in_addr  in  ADDR_W  line address; low OFF_W bits are ignored.
- in_bytes  in  16  transaction size, carried unchanged.
- in_last  in  1  final transaction of the current request.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accept.
- out_addr  out  ADDR_W  head address, low OFF_W bits zero.
- out_bytes  out  16  head size.
- out_last  out  1  head entry carries the request's last flag.
- out_merges  out  MERGE_W  number of duplicates folded into the head entry; saturates.
- req_done  out  1  one-cycle completion pulse.
- busy  out  1  FIFO non-empty, or a request is open (last_valid=1).

Behaviour:
- Reset: FIFO empty; out_valid=0, out_last=0, out_merges=0, out_addr=0, out_bytes=0, req_done=0, busy=0; last_valid=0. in_ready=1 in the cycle after reset deasserts.
- Reset asserted mid-operation discards all entries and any open request. No req_done is generated for a discarded request.
- in_ready = (count != DEPTH). It is driven from registered state only: no combinational path from out_ready, and no pop-bypass when the FIFO is full.
- Output signals are FIFO head state, with zero bypass. An accepted entry is visible no earlier than the next cycle.
- Push and pop in the same cycle are allowed; count is unchanged.
- Input address is normalised to in_addr with the low OFF_W bits forced to 0 ("line").
- last_addr / last_valid registers:
  - On every accepted input, last_addr <= line and last_valid <= !in_last.
  - last_valid=0 means the next input is the first transaction of a new request; it never dedupes across requests.
- Duplicate rule for an accepted input: dup = last_valid && (line == last_addr).
  - dup=0: enqueue {line, in_bytes, in_last, merges=0}.
  - dup=1, and the tail entry exists and is not being popped this cycle: no enqueue. The tail's merges increments, saturating at all-ones, and its last flag is ORed with in_last.
  - dup=1, and the FIFO is empty or the tail is popped this same cycle: input is dropped. If in_last=1, req_done pulses in the next cycle.
- Completion: req_done also pulses in the cycle after an out_valid && out_ready handshake with out_last=1. At most one pulse per request.
- Both sources cannot occur for the same request.
- Pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.

Optional Feature:
- Macro: LINE_DEDUP_WINDOW_EN.
- Defined:
  - A non-dup input (per the last_addr rule) is also compared against every valid FIFO entry that is not being popped this cycle.
  - On a match with in_last=0, the input merges into the youngest matching entry; merges increments.
  - On a match with in_last=1, the input merges only if that entry is the tail. Otherwise it is enqueued normally, so the last flag is never moved ahead of younger entries.
- Undefined: only the last_addr comparison is made. No per-entry comparators are built.

Test Plan:
- Reset, then idle → out_valid=0, in_ready=1, req_done=0, busy=0.
- out_ready=0; push 0x1000, 0x1000, 0x1000, 0x1080 (last); then out_ready=1 → two pops:
  - 0x1000 with merges=2, last=0;
  - 0x1080 with merges=0, last=1;
  - req_done pulses exactly once, the cycle after the second pop.
- Push 0x2000 and let it drain; then push 0x2000 with last=1 → no second output; req_done pulses one cycle after that input transfer.
- Backpressure: out_ready=0; push 0x0, 0x80, 0x100, 0x180 → in_ready=0 after the 4th push. A 5th input 0x200 is held until one pop, then accepted; output order is preserved.
- Misaligned input 0x1043 with a new request → out_addr=0x1000, out_bytes equals in_bytes.
- Push 0x0, 0x80, 0x0 (last=0), then 0x100 (last) →
  - with LINE_DEDUP_WINDOW_EN: 3 outputs, entry 0x0 has merges=1;
  - without it: 4 outputs, all with merges=0.
